fnn_mem_arbiter: RTL and testbench
==================================

# fnn_mem_arbiter

Burst-oriented round-robin arbiter sharing the single read port of the network's sample/weight memory between two requesters: the layer sequencer (input and weight fetch, one 8-neuron window per burst) and the result checker (label fetch). It accepts one burst request at a time, drives the memory read strobe and address for every beat, and routes each returning data word to the owning requester with valid and last markers. It sits between the network controller/checker and the memory, with no datapath arithmetic of its own.

## Interface
- AW, 10: memory address width.
- DW, 16: memory data width.
- LW, 3: burst length field width; the length field encodes beats minus one, so 1..8 beats.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  burst request from requester 0 (layer sequencer) / 1 (checker); held until the matching gnt.
- addr0 / addr1  in  AW  burst start address; stable while req is high.
- len0 / len1  in  LW  beats minus one; stable while req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: burst accepted.
- mem_read  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  DW  memory data, valid the cycle after mem_read.
- rdata  out  DW  forwarded mem_rdata, shared by both requesters.
- rvalid0 / rvalid1  out  1  rdata is a beat for requester 0 / 1.
- rlast  out  1  current rvalid beat is the final beat of the burst.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, TAIL.
- IDLE: if any req is high at the clock edge, select an owner, latch addr/len of the owner, set beat=0, and go to ISSUE. Otherwise stay in IDLE.
- Selection: if only one req is high, that requester wins. If both are high, the requester not granted last time wins. A 1-bit `last` register updates at every grant. Reset value of `last` is 1, so requester 0 wins the first tie.
- ISSUE: mem_read=1 and mem_addr = base + beat, modulo 2^AW (wraps silently). beat increments each cycle. When beat==len, go to TAIL.
- TAIL: no read is issued; the final beat returns. Then go to IDLE.
- Return path:
  - rvalid_owner is a registered copy of mem_read, tagged with the owner.
  - rlast is registered high for the beat issued with beat==len.
  - rdata is mem_rdata, combinational.
- gnt_owner is high only in the first ISSUE cycle.
- A requester may drop req before it is granted; no grant follows and no state changes.
- req is ignored in ISSUE and TAIL; a pending req is served at the next IDLE.
- len=0 gives a single-beat burst with one ISSUE cycle.
- Reset, at power-up or mid-burst:
  - State goes to IDLE; beat=0; `last`=1.
  - gnt0, gnt1, mem_read, rvalid0, rvalid1, rlast and busy are all 0.
  - mem_addr is 0.
  - No rvalid is produced for an aborted burst after rst deasserts.

## Timing
- req sampled high in IDLE at cycle c:
  - gnt and the first mem_read occur in cycle c+1.
  - beat i is read in cycle c+1+i and returns with rvalid in cycle c+2+i.
  - rlast is in cycle c+2+len, which is the TAIL cycle.
  - The FSM is back in IDLE at c+3+len.
- Earliest next gnt: c+4+len, so each burst occupies len+3 cycles.
- At most one rvalid is high per cycle; rvalid0 and rvalid1 are never high together.
- All outputs except rdata are registered or derived from state only; there are no combinational paths from req to any output.

## Test plan
- Single burst: req0 with addr0=0x010, len0=7 → gnt0 one cycle later; mem_addr 0x010..0x017 on 8 consecutive cycles; 8 rvalid0 beats with data matching the memory model; rlast on the 8th; rvalid1 never high.
- Tie and fairness: req0 and req1 held high continuously, both len=3 → grants alternate 0,1,0,1, starting with 0 after reset; each burst takes 6 cycles.
- Wrap and single beat: req1 with addr1=0x3FF, len1=1 → mem_addr 0x3FF then 0x000; a separate len=0 burst gives exactly one beat with rlast on it.
- Request while busy: req1 raised during req0's ISSUE → ignored until IDLE; gnt1 at c+4+len of the req0 burst; req1 withdrawn before grant → no gnt1.
- Reset mid-burst: rst pulsed during beat 3 of an 8-beat burst → all outputs 0 immediately; no rvalid after release; next tie grants requester 0.

Source files
------------

// File: rtl/fnn_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory read port.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters plus memory that surround it.
interface fnn_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16,
  parameter int LW = 3
);
  // Requester 0 (layer sequencer) and requester 1 (checker) burst requests
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [LW-1:0] len0;
  logic [LW-1:0] len1;
  logic          gnt0;
  logic          gnt1;

  // Memory read port
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  // Shared return path
  logic [DW-1:0] rdata;
  logic          rvalid0;
  logic          rvalid1;
  logic          rlast;
  logic          busy;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, mem_rdata,
    output gnt0, gnt1, mem_read, mem_addr, rdata, rvalid0, rvalid1, rlast, busy
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, mem_rdata,
    input  gnt0, gnt1, mem_read, mem_addr, rdata, rvalid0, rvalid1, rlast, busy
  );
endinterface

// File: rtl/fnn_mem_arbiter.sv
// Burst round-robin arbiter for the single read port of the sample/weight
// memory. One burst is accepted at a time; every beat is issued as a read and
// the returning word is tagged for the owning requester one cycle later.
module fnn_mem_arbiter #(
  parameter int AW = 10,
  parameter int LW = 3
) (
  input logic              clk,
  input logic              rst,
  fnn_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;

  logic          owner_reg;   // requester owning the current burst
  logic          last_reg;    // requester granted most recently
  logic [AW-1:0] base_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] beat_reg;
  logic [1:0]    gnt_reg;
  logic [1:0]    rvalid_reg;
  logic          rlast_reg;

  logic          any_req;
  logic          sel_owner;
  logic [AW-1:0] sel_addr;
  logic [LW-1:0] sel_len;
  logic          mem_read_c;
  logic          busy_c;
  logic [AW-1:0] mem_addr_c;
  logic          final_beat;

  assign any_req    = bus.req0 | bus.req1;
  assign final_beat = (beat_reg == len_reg);

  // Owner selection: a lone request wins, a tie goes to the one not granted last
  always_comb begin
    sel_owner = 1'b0;
    if (bus.req0 && !bus.req1) begin
      sel_owner = 1'b0;
    end else if (!bus.req0 && bus.req1) begin
      sel_owner = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      sel_owner = ~last_reg;
    end
    sel_addr = sel_owner ? bus.addr1 : bus.addr0;
    sel_len  = sel_owner ? bus.len1  : bus.len0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: requests are only looked at in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   if (final_beat) state_next = TAIL;
      TAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-derived outputs; the address is held at zero outside ISSUE
  always_comb begin
    mem_read_c = 1'b0;
    busy_c     = 1'b0;
    mem_addr_c = '0;
    case (state_reg)
      ISSUE: begin
        mem_read_c = 1'b1;
        busy_c     = 1'b1;
        mem_addr_c = base_reg + AW'(beat_reg);
      end
      TAIL:    busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
  end

  // Burst context capture on grant and beat counting while issuing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      base_reg  <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
      gnt_reg   <= '0;
    end else begin
      gnt_reg <= '0;
      if (state_reg == IDLE && any_req) begin
        owner_reg <= sel_owner;
        last_reg  <= sel_owner;
        base_reg  <= sel_addr;
        len_reg   <= sel_len;
        beat_reg  <= '0;
        gnt_reg   <= sel_owner ? 2'b10 : 2'b01;
      end else if (state_reg == ISSUE) begin
        beat_reg <= beat_reg + LW'(1);
      end
    end
  end

  // Return path: each read comes back one cycle later tagged with its owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_reg <= '0;
      rlast_reg  <= 1'b0;
    end else begin
      rvalid_reg <= {mem_read_c & owner_reg, mem_read_c & ~owner_reg};
      rlast_reg  <= mem_read_c & final_beat;
    end
  end

  assign bus.gnt0     = gnt_reg[0];
  assign bus.gnt1     = gnt_reg[1];
  assign bus.mem_read = mem_read_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.busy     = busy_c;
  assign bus.rvalid0  = rvalid_reg[0];
  assign bus.rvalid1  = rvalid_reg[1];
  assign bus.rlast    = rlast_reg;
  assign bus.rdata    = bus.mem_rdata;

endmodule

// File: tb/tb_fnn_mem_arbiter.sv
// Directed bench for fnn_mem_arbiter: single burst, tie fairness, address
// wrap, single-beat burst, requests while busy, withdrawn request and reset
// in the middle of a burst.
module tb_fnn_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fnn_mem_arbiter_if #(.AW(10), .DW(16), .LW(3)) bus ();

  fnn_mem_arbiter #(.AW(10), .LW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed function of the address
  function automatic logic [15:0] mdata(input logic [9:0] a);
    return {~a[5:0], a};
  endfunction

  // Synchronous-read memory model
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= mdata(bus.mem_addr);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follows a granted burst from its first ISSUE cycle (c+1) to the IDLE
  // cycle c+3+len, checking every output each cycle.
  task automatic burst(input bit who, input logic [9:0] a, input logic [2:0] l,
                       input bit drop, input int drop_other_k);
    logic [9:0] ea;
    for (int k = 0; k <= int'(l) + 1; k++) begin
      chk($sformatf("gnt_own w%0d k%0d", who, k), who ? bus.gnt1 : bus.gnt0, 32'(k == 0));
      chk($sformatf("gnt_oth w%0d k%0d", who, k), who ? bus.gnt0 : bus.gnt1, 0);
      chk($sformatf("mem_read k%0d", k), bus.mem_read, 32'(k <= int'(l)));
      if (k <= int'(l)) begin
        ea = a + 10'(k);
        chk($sformatf("mem_addr k%0d", k), bus.mem_addr, ea);
      end
      chk($sformatf("rvalid_own w%0d k%0d", who, k), who ? bus.rvalid1 : bus.rvalid0, 32'(k >= 1));
      chk($sformatf("rvalid_oth w%0d k%0d", who, k), who ? bus.rvalid0 : bus.rvalid1, 0);
      if (k >= 1) begin
        ea = a + 10'(k - 1);
        chk($sformatf("rdata k%0d", k), bus.rdata, mdata(ea));
      end
      chk($sformatf("rlast k%0d", k), bus.rlast, 32'(k == int'(l) + 1));
      chk($sformatf("busy k%0d", k), bus.busy, 1);
      if (k == 0 && drop) begin
        if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
      if (k == drop_other_k) begin
        if (who) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
      step();
    end
    chk("idle busy", bus.busy, 0);
    chk("idle mem_read", bus.mem_read, 0);
    chk("idle rvalid0", bus.rvalid0, 0);
    chk("idle rvalid1", bus.rvalid1, 0);
    chk("idle rlast", bus.rlast, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"}, bus.gnt0, 0);
    chk({tag, " gnt1"}, bus.gnt1, 0);
    chk({tag, " mem_read"}, bus.mem_read, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " rvalid0"}, bus.rvalid0, 0);
    chk({tag, " rvalid1"}, bus.rvalid1, 0);
    chk({tag, " rlast"}, bus.rlast, 0);
    chk({tag, " busy"}, bus.busy, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.len0  = '0;
    bus.len1  = '0;
    bus.mem_rdata = '0;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Single 8-beat burst from requester 0
    bus.req0 = 1'b1; bus.addr0 = 10'h010; bus.len0 = 3'd7;
    step();
    burst(1'b0, 10'h010, 3'd7, 1'b1, -1);
    step();

    // Tie fairness after a fresh reset: grants 0,1,0,1, six cycles each
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    bus.req0 = 1'b1; bus.addr0 = 10'h100; bus.len0 = 3'd3;
    bus.req1 = 1'b1; bus.addr1 = 10'h200; bus.len1 = 3'd3;
    step();
    burst(1'b0, 10'h100, 3'd3, 1'b0, -1);
    step();
    burst(1'b1, 10'h200, 3'd3, 1'b0, -1);
    step();
    burst(1'b0, 10'h100, 3'd3, 1'b1, -1);
    step();
    burst(1'b1, 10'h200, 3'd3, 1'b1, -1);
    step();

    // Address wrap on a two-beat burst, then a single-beat burst
    bus.req1 = 1'b1; bus.addr1 = 10'h3FF; bus.len1 = 3'd1;
    step();
    burst(1'b1, 10'h3FF, 3'd1, 1'b1, -1);
    bus.req0 = 1'b1; bus.addr0 = 10'h055; bus.len0 = 3'd0;
    step();
    burst(1'b0, 10'h055, 3'd0, 1'b1, -1);
    step();

    // req1 raised during req0's ISSUE is served at the next IDLE (c+4+len)
    bus.req0 = 1'b1; bus.addr0 = 10'h020; bus.len0 = 3'd2;
    step();
    bus.req1 = 1'b1; bus.addr1 = 10'h030; bus.len1 = 3'd0;
    burst(1'b0, 10'h020, 3'd2, 1'b1, -1);
    step();
    burst(1'b1, 10'h030, 3'd0, 1'b1, -1);
    step();

    // req1 raised then withdrawn while busy: never granted
    bus.req0 = 1'b1; bus.addr0 = 10'h040; bus.len0 = 3'd1;
    step();
    bus.req1 = 1'b1; bus.addr1 = 10'h050; bus.len1 = 3'd0;
    burst(1'b0, 10'h040, 3'd1, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("withdrawn gnt1 %0d", i), bus.gnt1, 0);
      chk($sformatf("withdrawn busy %0d", i), bus.busy, 0);
    end

    // Reset during beat 3 of an 8-beat burst
    bus.req0 = 1'b1; bus.addr0 = 10'h080; bus.len0 = 3'd7;
    step();
    chk("midrst gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    step();
    step();
    step();
    chk("midrst beat3 addr", bus.mem_addr, 10'h083);
    chk("midrst beat2 rvalid0", bus.rvalid0, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post rst rvalid0 %0d", i), bus.rvalid0, 0);
      chk($sformatf("post rst rvalid1 %0d", i), bus.rvalid1, 0);
      chk($sformatf("post rst busy %0d", i), bus.busy, 0);
    end

    // First tie after reset goes to requester 0
    bus.req0 = 1'b1; bus.addr0 = 10'h0A0; bus.len0 = 3'd0;
    bus.req1 = 1'b1; bus.addr1 = 10'h0B0; bus.len1 = 3'd0;
    step();
    burst(1'b0, 10'h0A0, 3'd0, 1'b1, -1);
    step();
    burst(1'b1, 10'h0B0, 3'd0, 1'b1, -1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
